// File: rtl/conv_pkg.sv
// conv_pkg: shared types, default widths and image-bus indexing helpers for the
// frame loader and the 3x3 convolver.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, FULL} state_t;

    localparam int DEF_TOTAL_BITS = 16;
    localparam int DEF_MAX_ROWS   = 8;
    localparam int DEF_MAX_COLS   = 8;
    localparam int DIM_W          = 4;
    localparam int MIN_DIM        = 3;

    // Row-major slot number of pixel (r,c) on a bus that is ncols wide.
    function automatic int slot_idx(input int r, input int c, input int ncols);
        return r * ncols + c;
    endfunction

    function automatic int bit_offset(input int r, input int c, input int ncols, input int bits);
        return slot_idx(r, c, ncols) * bits;
    endfunction

    function automatic logic dims_ok(input logic [DIM_W-1:0] r, input logic [DIM_W-1:0] c,
                                     input int mr, input int mc);
        return int'(r) >= MIN_DIM && int'(r) <= mr && int'(c) >= MIN_DIM && int'(c) <= mc;
    endfunction

endpackage

// File: rtl/pixel_index_counter.sv
// pixel_index_counter: row/column position of the next pixel in a row-major frame,
// wrapping the column at cols-1 and flagging the final pixel.
module pixel_index_counter
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIM_W-1:0] rows,
    input  logic [DIM_W-1:0] cols,
    output logic [DIM_W-1:0] r,
    output logic [DIM_W-1:0] c,
    output logic             last
);
    logic [DIM_W-1:0] r_q, c_q;

    assign r    = r_q;
    assign c    = c_q;
    assign last = (r_q == rows - 1'b1) && (c_q == cols - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            c_q <= '0;
        end else if (clear) begin
            r_q <= '0;
            c_q <= '0;
        end else if (advance) begin
            c_q <= (c_q == cols - 1'b1) ? '0 : c_q + 1'b1;
            r_q <= (c_q == cols - 1'b1) ? r_q + 1'b1 : r_q;
        end
    end

endmodule

// File: rtl/frame_loader.sv
// frame_loader: packs a row-major valid/ready pixel stream into the flattened image bus
// of the 3x3 convolver. Define FRAME_LOADER_DBUF_EN for a ping-pong (double) buffer.
module frame_loader
    import conv_pkg::*;
#(
    parameter int total_bits = DEF_TOTAL_BITS,
    parameter int max_rows   = DEF_MAX_ROWS,
    parameter int max_cols   = DEF_MAX_COLS
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [DIM_W-1:0]                       rows,
    input  logic [DIM_W-1:0]                       cols,
    input  logic [total_bits-1:0]                  pix_data,
    input  logic                                   pix_valid,
    output logic                                   pix_ready,
    output logic [max_rows*max_cols*total_bits-1:0] matrix_data,
    output logic                                   frame_valid,
    input  logic                                   frame_ack,
    output logic                                   busy,
    output logic                                   err_cfg
);
    localparam int N  = max_rows * max_cols;
    localparam int IW = $clog2(N);

    state_t           state_q, state_d;
    logic [DIM_W-1:0] rows_q, cols_q, r, c;
    logic             pix_ready_q, busy_q, frame_valid_q, err_cfg_q;
    logic             frame_valid_d, err_cfg_d, clear, accept, last, cfg_ok;
    logic [IW-1:0]    wr_idx;

    assign cfg_ok      = dims_ok(rows, cols, max_rows, max_cols);
    assign accept      = pix_valid && pix_ready_q;
    assign wr_idx      = IW'(slot_idx(int'(r), int'(c), max_cols));
    assign pix_ready   = pix_ready_q;
    assign busy        = busy_q;
    assign frame_valid = frame_valid_q;
    assign err_cfg     = err_cfg_q;

    pixel_index_counter u_idx (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .advance(accept),
        .rows   (rows_q),
        .cols   (cols_q),
        .r      (r),
        .c      (c),
        .last   (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rows_q        <= '0;
            cols_q        <= '0;
            pix_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            err_cfg_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rows_q        <= clear ? rows : rows_q;
            cols_q        <= clear ? cols : cols_q;
            pix_ready_q   <= state_d == LOAD;
            busy_q        <= state_d == LOAD || state_d == FULL;
            frame_valid_q <= frame_valid_d;
            err_cfg_q     <= err_cfg_d;
        end
    end

`ifdef FRAME_LOADER_DBUF_EN
    logic                  sel_q, swap;
    logic [total_bits-1:0] bank0_q [N];
    logic [total_bits-1:0] bank1_q [N];

    // sel_q names the front (presented) bank; loads always target the other one.
    always_comb begin
        state_d       = state_q;
        frame_valid_d = frame_valid_q;
        err_cfg_d     = 1'b0;
        clear         = 1'b0;
        swap          = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (state_q == HOLD && frame_ack) begin
                    frame_valid_d = 1'b0;
                    state_d       = IDLE;
                end else if (start) begin
                    clear     = cfg_ok;
                    err_cfg_d = !cfg_ok;
                    state_d   = cfg_ok ? LOAD : state_q;
                end
            end
            LOAD: begin
                frame_valid_d = frame_valid_q && !frame_ack;
                if (accept && last) begin
                    swap          = !frame_valid_q || frame_ack;
                    frame_valid_d = 1'b1;
                    state_d       = swap ? HOLD : FULL;
                end
            end
            FULL: begin
                swap    = frame_ack;
                state_d = frame_ack ? HOLD : FULL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                bank0_q[i] <= '0;
                bank1_q[i] <= '0;
            end
        end else begin
            sel_q <= sel_q ^ swap;
            for (int i = 0; i < N; i++) begin
                if (clear && sel_q) bank0_q[i] <= '0;
                if (clear && !sel_q) bank1_q[i] <= '0;
            end
            if (accept && sel_q) bank0_q[wr_idx] <= pix_data;
            if (accept && !sel_q) bank1_q[wr_idx] <= pix_data;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_out
        assign matrix_data[g*total_bits +: total_bits] = sel_q ? bank1_q[g] : bank0_q[g];
    end
`else
    logic [total_bits-1:0] buf_q [N];

    always_comb begin
        state_d   = state_q;
        err_cfg_d = 1'b0;
        clear     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                clear     = cfg_ok;
                err_cfg_d = !cfg_ok;
                state_d   = cfg_ok ? LOAD : IDLE;
            end
            LOAD: state_d = (accept && last) ? HOLD : LOAD;
            HOLD: state_d = frame_ack ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
        frame_valid_d = state_d == HOLD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) buf_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) buf_q[i] <= '0;
        end else if (accept) begin
            buf_q[wr_idx] <= pix_data;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_out
        assign matrix_data[g*total_bits +: total_bits] = buf_q[g];
    end
`endif

endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: randomized scoreboard bench for frame_loader; expected frames are
// built from the pixel lists and checked by a monitor whenever a new frame is presented.
module tb_frame_loader;
    localparam int TB = 16;
    localparam int MR = 8;
    localparam int MC = 8;
    localparam int NS = MR * MC;
    localparam int W  = NS * TB;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, pix_valid = 1'b0, frame_ack = 1'b0;
    logic [3:0]    rows = '0, cols = '0;
    logic [TB-1:0] pix_data = '0;
    logic          pix_ready, frame_valid, busy, err_cfg;
    logic [W-1:0]  matrix_data;

    int            checks = 0, failures = 0, err_seen = 0, err_exp = 0;
    logic [W-1:0]  exp_q[$];
    logic [TB-1:0] cur_px[$];
    logic [W-1:0]  last_exp, frame_a;
    logic          fv_prev = 1'b0, ack_prev = 1'b0;

    frame_loader #(.total_bits(TB), .max_rows(MR), .max_cols(MC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rows       (rows),
        .cols       (cols),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .matrix_data(matrix_data),
        .frame_valid(frame_valid),
        .frame_ack  (frame_ack),
        .busy       (busy),
        .err_cfg    (err_cfg)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_frame(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int s = 0; s < NS; s++) begin
                if (act[s*TB +: TB] !== exp[s*TB +: TB]) begin
                    $display("FAIL %s: slot (%0d,%0d) got %0h, expected %0h",
                             name, s / MC, s % MC, act[s*TB +: TB], exp[s*TB +: TB]);
                    break;
                end
            end
        end
    endtask

    // Reference image: pixel i of an nr x nc frame lands at row i/nc, column i%nc.
    function automatic logic [W-1:0] model_frame(input int nr, input int nc, input logic [TB-1:0] px[$]);
        logic [W-1:0] f = '0;
        foreach (px[i]) f[((i / nc) * MC + i % nc) * TB +: TB] = px[i];
        return f;
    endfunction

    always @(negedge clk) begin
        if (rst_n && frame_valid && (!fv_prev || ack_prev)) begin
            if (exp_q.size() == 0) chk("frame_unexpected", 32'd1, 32'd0);
            else chk_frame("frame_content", matrix_data, exp_q.pop_front());
        end
        if (err_cfg) err_seen++;
        fv_prev  = frame_valid;
        ack_prev = frame_ack && frame_valid;
    end

    task automatic launch(input int nr, input int nc, input bit fixed);
        cur_px.delete();
        for (int i = 0; i < nr * nc; i++) cur_px.push_back(fixed ? TB'(i + 1) : TB'($urandom));
        last_exp = model_frame(nr, nc, cur_px);
        exp_q.push_back(last_exp);
        start = 1'b1;
        rows  = 4'(nr);
        cols  = 4'(nc);
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("ready_after_start", pix_ready, 1);
    endtask

    task automatic feed(input int n, input bit toggle, input bit chk_fv);
        int i = 0;
        int cyc = 0;
        while (i < n && cyc < 4 * n + 20) begin
            bit acc;
            pix_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            pix_data  = cur_px[i];
            acc = pix_valid && pix_ready;
            tick();
            cyc++;
            if (acc) i++;
            if (chk_fv && i < n) chk("fv_before_last", frame_valid, 0);
        end
        pix_valid = 1'b0;
        if (i < n) chk("feed_timeout", i, n);
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("fv_after_ack", frame_valid, 0);
    endtask

    task automatic bad_start(input logic [3:0] nr, input logic [3:0] nc);
        start = 1'b1;
        rows  = nr;
        cols  = nc;
        tick();
        start = 1'b0;
        err_exp++;
        chk("err_pulse", err_cfg, 1);
        chk("err_busy", busy, 0);
        chk("err_ready", pix_ready, 0);
        tick();
        chk("err_drop", err_cfg, 0);
        chk("err_busy2", busy, 0);
        chk("err_ready2", pix_ready, 0);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_ready", pix_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_err", err_cfg, 0);
        chk_frame("rst_matrix", matrix_data, '0);
        rst_n = 1'b1;
        tick();

        // 3x3 frame of 1..9 back-to-back
        launch(3, 3, 1'b1);
        feed(9, 1'b0, 1'b1);
        chk("fv_after_last_3x3", frame_valid, 1);
        chk("busy_after_last", busy, 0);
        chk("ready_after_last", pix_ready, 0);
        chk("slot_0_2", matrix_data[2*TB +: TB], 3);
        chk("slot_2_2", matrix_data[(2*MC+2)*TB +: TB], 9);
        ack();

        // stray pixels while idle must not touch the retained frame
        pix_valid = 1'b1;
        pix_data  = TB'($urandom);
        repeat (3) tick();
        pix_valid = 1'b0;
        chk_frame("idle_pix_ignored", matrix_data, last_exp);

        // full 8x8 with pix_valid toggling
        launch(8, 8, 1'b0);
        feed(64, 1'b1, 1'b1);
        chk("fv_after_last_8x8", frame_valid, 1);
        ack();

        bad_start(4'd2, 4'd5);
        bad_start(4'd9, 4'd3);

        // reset in the middle of a 6x6 load
        launch(6, 6, 1'b0);
        feed(20, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", pix_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_fv", frame_valid, 0);
        chk_frame("midrst_matrix", matrix_data, '0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        launch(6, 6, 1'b0);
        feed(36, 1'b0, 1'b1);
        chk("fv_after_last_6x6", frame_valid, 1);
        ack();

        // long hold with no ack
        launch(4, 5, 1'b0);
        feed(20, 1'b0, 1'b1);
        for (int k = 0; k < 50; k++) begin
`ifndef FRAME_LOADER_DBUF_EN
            start = (k == 20);
            rows  = 4'd4;
            cols  = 4'd4;
`endif
            tick();
            chk_frame("hold_data", matrix_data, last_exp);
            chk("hold_fv", frame_valid, 1);
        end
        start = 1'b0;
        chk("hold_busy", busy, 0);
        chk("hold_ready", pix_ready, 0);
        ack();
        chk_frame("retained_after_ack", matrix_data, last_exp);

`ifdef FRAME_LOADER_DBUF_EN
        // frame A presented, frame B loaded behind it and stalled until ack
        launch(3, 4, 1'b0);
        feed(12, 1'b0, 1'b1);
        chk("dbuf_fv_a", frame_valid, 1);
        frame_a = last_exp;
        launch(5, 5, 1'b0);
        feed(25, 1'b0, 1'b0);
        repeat (5) begin
            chk("full_ready", pix_ready, 0);
            chk("full_busy", busy, 1);
            chk("full_fv", frame_valid, 1);
            chk_frame("full_front_a", matrix_data, frame_a);
            tick();
        end
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("swap_fv", frame_valid, 1);
        chk_frame("swap_front_b", matrix_data, last_exp);
        ack();
`endif

        repeat (2) tick();
        chk("err_pulses", err_seen, err_exp);
        chk("frames_left", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
